// File: rtl/vec_alu_pkg.sv
// Shared encodings for the vector ALU: operation and element-width types,
// plus lane sizing and encoding-validity helpers.
package vec_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_AND  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_XOR  = 4'd9,
        ALU_NONE = 4'd10,
        ALU_MIN  = 4'd11,
        ALU_MAX  = 4'd12,
        ALU_MINU = 4'd13,
        ALU_MAXU = 4'd14
    } alu_op_t;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2
    } sew_t;

    localparam int unsigned MinSew = 8;

    function automatic int unsigned max_elems_per_lane(input int unsigned xlen);
        return xlen / MinSew;
    endfunction

    function automatic logic op_is_defined(input alu_op_t op);
        return (4'(op) <= 4'(ALU_MAXU));
    endfunction

    function automatic logic sew_is_defined(input sew_t sew);
        return (2'(sew) != 2'd3);
    endfunction

endpackage

// File: rtl/vec_alu_if.sv
// Request/response bundle between the register-file read stage, the vector
// ALU and the writeback arbiter.
interface vec_alu_if
    import vec_alu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NumLanes = 4
);
    localparam int unsigned MaskW = NumLanes * XLEN / 8;

    logic                               in_valid_i;
    logic                               in_ready_o;
    alu_op_t                            alu_op_i;
    sew_t                               sew_i;
    logic [NumLanes-1:0][XLEN-1:0]      vs1_i;
    logic [NumLanes-1:0][XLEN-1:0]      vs2_i;
    logic [NumLanes-1:0][XLEN-1:0]      vd_old_i;
    logic [MaskW-1:0]                   mask_i;
    logic                               out_valid_o;
    logic                               out_ready_i;
    logic [NumLanes-1:0][XLEN-1:0]      result_o;

    modport slave (
        input  in_valid_i, alu_op_i, sew_i, vs1_i, vs2_i, vd_old_i, mask_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o
    );

    modport master (
        output in_valid_i, alu_op_i, sew_i, vs1_i, vs2_i, vd_old_i, mask_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o
    );

endinterface

// File: rtl/vec_alu_lane.sv
// Combinational single-lane element engine: computes every element at all three
// widths, applies the element mask, then selects the active width.
module vec_alu_lane
    import vec_alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  sew_t                i_sew,
    input  alu_op_t             i_op,
    input  logic [XLEN-1:0]     i_a,
    input  logic [XLEN-1:0]     i_b,
    input  logic [XLEN-1:0]     i_old,
    input  logic [XLEN/8-1:0]   i_mask,
    output logic [XLEN-1:0]     o_result
);

    // Operands are left-justified so wrap, signed compare and SRA sign fill come
    // for free at any width; the result is shifted back down afterwards.
    function automatic logic [31:0] elem_alu(input alu_op_t op, input logic [31:0] a,
                                             input logic [31:0] b, input int unsigned w);
        logic [31:0] a_j;
        logic [31:0] b_j;
        logic [31:0] r;
        logic [4:0]  pad;
        logic [4:0]  sh;
        logic        lt_s;
        logic        lt_u;
        pad  = 5'(32 - w);
        a_j  = a << pad;
        b_j  = b << pad;
        sh   = 5'(b & (w - 1));
        lt_s = ($signed(a_j) < $signed(b_j));
        lt_u = (a_j < b_j);
        case (op)
            ALU_ADD:  r = (a_j + b_j) >> pad;
            ALU_SUB:  r = (a_j - b_j) >> pad;
            ALU_SLL:  r = (a_j << sh) >> pad;
            ALU_SRL:  r = (a_j >> sh) >> pad;
            ALU_SRA:  r = 32'($signed(a_j) >>> sh) >> pad;
            ALU_SLT:  r = {31'd0, lt_s};
            ALU_SLTU: r = {31'd0, lt_u};
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NONE: r = b;
            ALU_MIN:  r = lt_s ? a : b;
            ALU_MAX:  r = lt_s ? b : a;
            ALU_MINU: r = lt_u ? a : b;
            ALU_MAXU: r = lt_u ? b : a;
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

    logic [2:0][XLEN-1:0] w_res;

    for (genvar s = 0; s < 3; s++) begin : g_sew
        localparam int unsigned W = 8 << s;
        for (genvar e = 0; e < XLEN / W; e++) begin : g_elem
            logic [W-1:0] w_elem;
            assign w_elem = W'(elem_alu(i_op, 32'(i_a[e*W +: W]), 32'(i_b[e*W +: W]), W));
            assign w_res[s][e*W +: W] = i_mask[e] ? w_elem : i_old[e*W +: W];
        end
    end

    // Width select; undefined op or width encodings yield an all-zero lane.
    always_comb begin
        o_result = '0;
        if (op_is_defined(i_op)) begin
            case (i_sew)
                SEW_8:   o_result = w_res[0];
                SEW_16:  o_result = w_res[1];
                SEW_32:  o_result = w_res[2];
                default: o_result = '0;
            endcase
        end else begin
            o_result = '0;
        end
    end

endmodule

// File: rtl/vec_alu.sv
// Two-stage pipelined, lane-parallel vector ALU with valid/ready on both sides.
// S1 holds the request, S2 holds the masked result.
module vec_alu
    import vec_alu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NumLanes = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    vec_alu_if.slave bus
);

    localparam int unsigned MaskW     = NumLanes * XLEN / 8;
    localparam int unsigned LaneMaskW = max_elems_per_lane(XLEN);

    logic                                r_s1_valid;
    alu_op_t                             r_s1_op;
    sew_t                                r_s1_sew;
    logic [NumLanes-1:0][XLEN-1:0]       r_s1_a;
    logic [NumLanes-1:0][XLEN-1:0]       r_s1_b;
    logic [NumLanes-1:0][XLEN-1:0]       r_s1_old;
    logic [MaskW-1:0]                    r_s1_mask;
    logic                                r_s2_valid;
    logic [NumLanes-1:0][XLEN-1:0]       r_s2_result;

    logic                                w_s1_adv;
    logic                                w_s2_adv;
    logic [NumLanes-1:0][LaneMaskW-1:0]  w_lane_mask;
    logic [NumLanes-1:0][XLEN-1:0]       w_lane_res;

    assign w_s2_adv        = !r_s2_valid || bus.out_ready_i;
    assign w_s1_adv        = !r_s1_valid || w_s2_adv;
    assign bus.in_ready_o  = w_s1_adv;
    assign bus.out_valid_o = r_s2_valid;
    assign bus.result_o    = r_s2_result;

    // Each lane sees only its own elements' mask bits for the selected width.
    always_comb begin
        w_lane_mask = '0;
        for (int l = 0; l < NumLanes; l++) begin
            case (r_s1_sew)
                SEW_8:   w_lane_mask[l] = LaneMaskW'(r_s1_mask[l*(XLEN/8)  +: XLEN/8]);
                SEW_16:  w_lane_mask[l] = LaneMaskW'(r_s1_mask[l*(XLEN/16) +: XLEN/16]);
                SEW_32:  w_lane_mask[l] = LaneMaskW'(r_s1_mask[l*(XLEN/32) +: XLEN/32]);
                default: w_lane_mask[l] = '0;
            endcase
        end
    end

    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        vec_alu_lane #(.XLEN(XLEN)) u_lane (
            .i_sew    (r_s1_sew),
            .i_op     (r_s1_op),
            .i_a      (r_s1_a[l]),
            .i_b      (r_s1_b[l]),
            .i_old    (r_s1_old[l]),
            .i_mask   (w_lane_mask[l]),
            .o_result (w_lane_res[l])
        );
    end

    // Pipeline registers; a stage only loads data when a valid beat enters it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= ALU_ADD;
            r_s1_sew    <= SEW_8;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_old    <= '0;
            r_s1_mask   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= bus.in_valid_i;
                if (bus.in_valid_i) begin
                    r_s1_op   <= bus.alu_op_i;
                    r_s1_sew  <= bus.sew_i;
                    r_s1_a    <= bus.vs1_i;
                    r_s1_b    <= bus.vs2_i;
                    r_s1_old  <= bus.vd_old_i;
                    r_s1_mask <= bus.mask_i;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_result <= w_lane_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_alu.sv
// Scoreboard bench for vec_alu (XLEN=32, 4 lanes): directed vectors, back-pressure,
// latency/throughput, mid-stream reset and a random sweep against a reference model.
module tb_vec_alu;
    import vec_alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_alu_if #(.XLEN(32), .NumLanes(4)) bus ();
    vec_alu #(.XLEN(32), .NumLanes(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [127:0]  exp_q[$];
    int            cyc = 0;
    int            n_out = 0;
    int            n_acc = 0;
    int            acc_cyc = 0;
    int            first_out_cyc = -1;
    int            last_out_cyc = -1;
    bit            drv_done;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent element model: extract, sign-extend via arithmetic, recombine.
    function automatic logic [127:0] model(input alu_op_t op, input sew_t sew, input logic [127:0] a,
                                           input logic [127:0] b, input logic [127:0] old,
                                           input logic [15:0] m);
        logic [127:0] res;
        logic [63:0]  mw, ea, eb, r;
        longint       sa, sb;
        int           w, sh;
        res = '0;
        if (2'(sew) == 2'd3 || 4'(op) == 4'd15) return res;
        w  = 8 << int'(sew);
        mw = (64'd1 << w) - 64'd1;
        for (int k = 0; k < 128 / w; k++) begin
            ea = 64'(a >> (k * w)) & mw;
            eb = 64'(b >> (k * w)) & mw;
            sa = longint'(ea);
            sb = longint'(eb);
            if (ea[w-1]) sa = sa - (longint'(1) << w);
            if (eb[w-1]) sb = sb - (longint'(1) << w);
            sh = int'(eb % 64'(w));
            case (op)
                ALU_ADD:  r = ea + eb;
                ALU_SUB:  r = ea - eb;
                ALU_SLL:  r = ea << sh;
                ALU_SRL:  r = ea >> sh;
                ALU_SRA:  r = 64'(sa >>> sh);
                ALU_SLT:  r = (sa < sb) ? 64'd1 : 64'd0;
                ALU_SLTU: r = (ea < eb) ? 64'd1 : 64'd0;
                ALU_AND:  r = ea & eb;
                ALU_OR:   r = ea | eb;
                ALU_XOR:  r = ea ^ eb;
                ALU_NONE: r = eb;
                ALU_MIN:  r = (sa <= sb) ? ea : eb;
                ALU_MAX:  r = (sa >= sb) ? ea : eb;
                ALU_MINU: r = (ea <= eb) ? ea : eb;
                ALU_MAXU: r = (ea >= eb) ? ea : eb;
                default:  r = 64'd0;
            endcase
            if (!m[k]) r = 64'(old >> (k * w));
            res = res | (128'(r & mw) << (k * w));
        end
        return res;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Consumption monitor: every handshake-completed beat is checked in order.
    always @(negedge clk) begin
        if (!rst && bus.out_valid_o && bus.out_ready_i) begin
            n_out++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            if (exp_q.size() == 0) check_val("spurious_out", 128'(n_out), 128'(n_acc));
            else                   check_val("result", bus.result_o, exp_q.pop_front());
        end
    end

    task automatic send_beat(input alu_op_t op, input sew_t sew, input logic [127:0] a,
                             input logic [127:0] b, input logic [127:0] old,
                             input logic [15:0] m, input logic [127:0] exp);
        bit ok;
        ok = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.alu_op_i   = op;
        bus.sew_i      = sew;
        bus.vs1_i      = a;
        bus.vs2_i      = b;
        bus.vd_old_i   = old;
        bus.mask_i     = m;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) ok = 1'b1;
        end
        if (ok) begin
            exp_q.push_back(exp);
            n_acc++;
            acc_cyc = cyc;
        end else begin
            check_val("in_ready_timeout", 128'(bus.in_ready_o), 128'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_rand();
        alu_op_t      op;
        sew_t         sew;
        logic [127:0] a, b, old;
        logic [15:0]  m;
        op  = alu_op_t'(4'($urandom_range(0, 15)));
        sew = sew_t'(2'($urandom_range(0, 3)));
        a   = {$urandom, $urandom, $urandom, $urandom};
        b   = {$urandom, $urandom, $urandom, $urandom};
        old = {$urandom, $urandom, $urandom, $urandom};
        m   = 16'($urandom);
        send_beat(op, sew, a, b, old, m, model(op, sew, a, b, old, m));
    endtask

    task automatic idle();
        bus.in_valid_i = 1'b0;
        bus.vs1_i      = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check_val("drain", 128'(exp_q.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc_first;
        int out_snap;
        bus.in_valid_i  = 1'b0;
        bus.alu_op_i    = ALU_ADD;
        bus.sew_i       = SEW_8;
        bus.vs1_i       = '0;
        bus.vs2_i       = '0;
        bus.vd_old_i    = '0;
        bus.mask_i      = '0;
        bus.out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("reset_out_valid", 128'(bus.out_valid_o), 128'd0);
        check_val("reset_in_ready",  128'(bus.in_ready_o),  128'd1);
        check_val("reset_result",    bus.result_o,          128'd0);
        @(posedge clk); #1;

        // Directed vectors, replicated across all four lanes.
        send_beat(ALU_ADD,  SEW_8,  {4{32'h7F01FF80}}, {4{32'h01FF0180}}, '0, 16'hFFFF, {4{32'h80000000}});
        send_beat(ALU_SRA,  SEW_16, {4{32'h80004000}}, {4{32'h00040001}}, '0, 16'hFFFF, {4{32'hF8002000}});
        send_beat(ALU_SRA,  SEW_32, {4{32'h80000000}}, {4{32'h00000021}}, '0, 16'hFFFF, {4{32'hC0000000}});
        send_beat(ALU_SLT,  SEW_32, {4{32'hFFFFFFFF}}, {4{32'h00000001}}, '0, 16'hFFFF, {4{32'h00000001}});
        send_beat(ALU_SLTU, SEW_32, {4{32'hFFFFFFFF}}, {4{32'h00000001}}, '0, 16'hFFFF, {4{32'h00000000}});
        send_beat(ALU_MINU, SEW_8,  {4{32'h00FF1080}}, {4{32'h01012070}}, '0, 16'hFFFF, {4{32'h00011070}});
        send_beat(ALU_XOR,  SEW_8,  {4{32'hFFFFFFFF}}, '0, {4{32'h11223344}}, 16'h5555, {4{32'h11FF33FF}});
        send_beat(ALU_ADD,  sew_t'(2'd3), {4{32'h12345678}}, {4{32'h11111111}}, {4{32'hDEADBEEF}},
                  16'hFFFF, 128'd0);
        send_beat(alu_op_t'(4'd15), SEW_8, {4{32'h12345678}}, {4{32'h11111111}}, {4{32'hDEADBEEF}},
                  16'hFFFF, 128'd0);
        idle();
        drain();

        // Back-pressure: consumer stalls for five cycles while six beats stream in.
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand();
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready_i = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check_val("bp_in_ready",  128'(bus.in_ready_o),  128'd0);
                check_val("bp_out_valid", 128'(bus.out_valid_o), 128'd1);
                check_val("bp_held",      128'(exp_q.size()),    128'd2);
                repeat (3) @(posedge clk);
                #1 bus.out_ready_i = 1'b1;
            end
        join
        drain();

        // Latency and full-rate throughput with the consumer always ready.
        first_out_cyc = -1;
        send_rand();
        acc_first = acc_cyc;
        for (int i = 0; i < 3; i++) send_rand();
        idle();
        drain();
        check_val("latency",    128'(first_out_cyc - acc_first),    128'd2);
        check_val("throughput", 128'(last_out_cyc - first_out_cyc), 128'd3);

        // Reset with two beats in flight.
        send_rand();
        send_rand();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_mid_out_valid", 128'(bus.out_valid_o), 128'd0);
        check_val("rst_mid_in_ready",  128'(bus.in_ready_o),  128'd1);
        check_val("rst_mid_result",    bus.result_o,          128'd0);
        n_acc = n_acc - exp_q.size();
        exp_q.delete();
        out_snap = n_out;
        repeat (6) @(posedge clk);
        check_val("rst_no_stale", 128'(n_out), 128'(out_snap));
        #1;

        // Random sweep with a randomly stalling consumer.
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send_rand();
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk); #1;
                    end
                end
                idle();
                drv_done = 1'b1;
            end
            begin
                for (int g = 0; g < 2000 && !drv_done; g++) begin
                    @(posedge clk);
                    #1 bus.out_ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
